// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmit path between N byte producers.
// Grants one requester, strobes load then SEND, and waits for NINTO (with timeout) plus a gap.
module uart_tx_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     ack,
    output logic             load,
    output logic             SEND,
    output logic [7:0]       Tx_Data,
    input  logic             NINTO,
    output logic             busy,
    output logic [2:0]       grant_id,
    output logic             timeout_err,
    input  logic             clr_err
);

    localparam int unsigned WCW = $clog2(TIMEOUT);
    localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP} state_t;

    state_t         state, state_n;
    logic [2:0]     rr_ptr, rr_ptr_n;
    logic [WCW-1:0] wcnt, wcnt_n;
    logic [GCW-1:0] gcnt, gcnt_n;

    logic [N-1:0]   ack_n;
    logic           load_n, send_n, busy_n, err_n;
    logic [7:0]     data_n;
    logic [2:0]     grant_n;

    logic           found;
    logic [2:0]     win;
    logic [7:0]     data_sel;
    logic [N-1:0]   ack_sel;

    // Winner search: first set request after the pointer, wrapping modulo N.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        data_sel = '0;
        ack_sel  = '0;
        for (int k = 1; k <= int'(N); k++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!found && ((int'(rr_ptr) + k) % int'(N) == i) && req[i]) begin
                    found = 1'b1;
                    win   = 3'(i);
                end
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (3'(i) == win) begin
                data_sel   = req_data[8*i +: 8];
                ack_sel[i] = found;
            end
        end
    end

    // Next-state and next-output logic; every output is the registered copy of these.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        wcnt_n   = wcnt;
        gcnt_n   = gcnt;
        ack_n    = '0;
        load_n   = 1'b0;
        send_n   = 1'b0;
        data_n   = Tx_Data;
        grant_n  = grant_id;
        err_n    = timeout_err;

        if (clr_err) begin
            err_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n  = S_LOAD;
                    data_n   = data_sel;
                    grant_n  = win;
                    rr_ptr_n = win;
                    ack_n    = ack_sel;
                    load_n   = 1'b1;
                end
            end
            S_LOAD: begin
                state_n = S_SEND;
                send_n  = 1'b1;
            end
            S_SEND: begin
                state_n = S_WAIT;
                wcnt_n  = '0;
            end
            S_WAIT: begin
                if (!NINTO) begin
                    state_n = S_GAP;
                    gcnt_n  = '0;
                end else if (wcnt == WAIT_LAST) begin
                    // Timeout set outranks a same-cycle clear.
                    err_n   = 1'b1;
                    state_n = S_GAP;
                    gcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + WCW'(1);
                end
            end
            S_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    gcnt_n = gcnt + GCW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            rr_ptr      <= 3'(N - 1);
            wcnt        <= '0;
            gcnt        <= '0;
            ack         <= '0;
            load        <= 1'b0;
            SEND        <= 1'b0;
            Tx_Data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            wcnt        <= wcnt_n;
            gcnt        <= gcnt_n;
            ack         <= ack_n;
            load        <= load_n;
            SEND        <= send_n;
            Tx_Data     <= data_n;
            busy        <= busy_n;
            grant_id    <= grant_n;
            timeout_err <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, reset/clear sequences,
// then random transfers checked against a round-robin transaction model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int GAP = 2;

    logic          Clock, Reset;
    logic [N-1:0]  req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  ack;
    logic          load, SEND, busy, timeout_err, clr_err, NINTO;
    logic [7:0]    Tx_Data;
    logic [2:0]    grant_id;

    int vectors    = 0;
    int miscompares = 0;
    int ptr;
    bit merr;

    uart_tx_arbiter #(.N(N), .TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
        .Clock(Clock), .Reset(Reset), .req(req), .req_data(req_data),
        .ack(ack), .load(load), .SEND(SEND), .Tx_Data(Tx_Data), .NINTO(NINTO),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] data;
        int          d;
        bit          drop;
        bit          clr_last;
        int          ew;
        logic [7:0]  eb;
        bit          ee;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Model: first requester strictly after the last grant, modulo N.
    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One full transfer, starting in an IDLE cycle; NINTO goes low in WAIT cycle d (d >= TMO: never).
    task automatic xfer(input logic [3:0] rq, input logic [31:0] data, input int d,
                        input bit drop, input bit clr_last, input int ew,
                        input logic [7:0] eb, input bit ee);
        logic [3:0] r;
        r = rq;
        req = r; req_data = data; NINTO = 1'b1; clr_err = 1'b0;
        step();
        chk("ack", 32'(ack), 32'(1 << ew));
        chk("load", 32'(load), 32'd1);
        chk("tx_data", 32'(Tx_Data), 32'(eb));
        chk("grant_id", 32'(grant_id), 32'(ew));
        chk("busy_load", 32'(busy), 32'd1);
        chk("send_early", 32'(SEND), 32'd0);
        if (drop) r[ew] = 1'b0;
        req = r;
        req_data = $urandom();
        step();
        chk("send", 32'(SEND), 32'd1);
        chk("load_off", 32'(load), 32'd0);
        chk("ack_off", 32'(ack), 32'd0);
        for (int j = 0; j < TMO; j++) begin
            step();
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_strobes", {29'd0, SEND, load, |ack}, 32'd0);
            clr_err = clr_last && (j == TMO - 1);
            if (j == d) begin
                NINTO = 1'b0;
                break;
            end
        end
        for (int g = 0; g < GAP; g++) begin
            step();
            clr_err = 1'b0;
            NINTO = 1'($urandom());
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_err", 32'(timeout_err), 32'(ee));
        end
        step();
        NINTO = 1'b1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(timeout_err), 32'(ee));
        chk("tx_hold", 32'(Tx_Data), 32'(eb));
        chk("grant_hold", 32'(grant_id), 32'(ew));
    endtask

    task automatic idle(input bit clr);
        req = '0; clr_err = clr;
        step();
        clr_err = 1'b0;
        if (clr) merr = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(timeout_err), 32'(merr));
        chk("idle_load", 32'(load), 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {ack, load, SEND, Tx_Data, busy, grant_id, timeout_err}, 32'd0);
    endtask

    initial begin
        logic [3:0]  rq;
        logic [31:0] data;
        int          d, w;
        bit          drop;

        tbl[0]  = '{4'b1111, 32'h13121110, 3,  1'b0, 1'b0, 0, 8'h10, 1'b0};
        tbl[1]  = '{4'b1111, 32'h13121110, 5,  1'b0, 1'b0, 1, 8'h11, 1'b0};
        tbl[2]  = '{4'b1111, 32'h13121110, 0,  1'b0, 1'b0, 2, 8'h12, 1'b0};
        tbl[3]  = '{4'b1111, 32'h13121110, 7,  1'b0, 1'b0, 3, 8'h13, 1'b0};
        tbl[4]  = '{4'b1111, 32'h13121110, 2,  1'b0, 1'b0, 0, 8'h10, 1'b0};
        tbl[5]  = '{4'b1010, 32'h23002100, 4,  1'b1, 1'b0, 1, 8'h21, 1'b0};
        tbl[6]  = '{4'b1000, 32'h23000000, 1,  1'b0, 1'b0, 3, 8'h23, 1'b0};
        tbl[7]  = '{4'b1000, 32'h23000000, 6,  1'b0, 1'b0, 3, 8'h23, 1'b0};
        tbl[8]  = '{4'b0100, 32'h003C0000, 9,  1'b1, 1'b0, 2, 8'h3C, 1'b0};
        tbl[9]  = '{4'b0001, 32'h00000055, 15, 1'b1, 1'b0, 0, 8'h55, 1'b0};
        tbl[10] = '{4'b0010, 32'h00006600, 16, 1'b1, 1'b0, 1, 8'h66, 1'b1};
        tbl[11] = '{4'b0100, 32'h00770000, 16, 1'b1, 1'b1, 2, 8'h77, 1'b1};

        Reset = 1'b1; req = '0; req_data = '0; NINTO = 1'b1; clr_err = 1'b0;
        repeat (3) step();
        chk_all_zero("reset_state");
        Reset = 1'b0;
        ptr = N - 1; merr = 1'b0;

        for (int v = 0; v < 12; v++) begin
            xfer(tbl[v].rq, tbl[v].data, tbl[v].d, tbl[v].drop, tbl[v].clr_last,
                 tbl[v].ew, tbl[v].eb, tbl[v].ee);
            ptr = tbl[v].ew;
            merr = tbl[v].ee;
        end

        // Clear the sticky error, then raise it again before the reset test.
        idle(1'b1);
        idle(1'b0);
        xfer(4'b1001, 32'h99000088, 20, 1'b1, 1'b0, 3, 8'h99, 1'b1);
        ptr = 3; merr = 1'b1;

        // Reset taken mid-WAIT, then requester 0 is served again.
        req = 4'b0001; req_data = 32'h000000A5; NINTO = 1'b1;
        step();
        chk("rst_pre_load", 32'(load), 32'd1);
        step();
        step();
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk_all_zero("reset_mid_wait");
        ptr = N - 1; merr = 1'b0;
        xfer(4'b0001, 32'h000000A5, 2, 1'b0, 1'b0, 0, 8'hA5, 1'b0);
        ptr = 0;

        for (int t = 0; t < 40; t++) begin
            rq   = 4'($urandom_range(1, 15));
            data = $urandom();
            d    = int'($urandom_range(0, TMO + 3));
            drop = 1'($urandom());
            w    = pick(ptr, rq);
            if (d >= TMO) merr = 1'b1;
            xfer(rq, data, d, drop, 1'b0, w, data[8*w +: 8], merr);
            ptr = w;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                idle($urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
